// File: rtl/credit_arb_pkg.sv
// -----------------------------------------------------------------------------
// credit_arb_pkg
// Shared types and helpers for the credit-based round-robin arbiter.
//   arb_state_e : arbiter mode (RUN, DRAIN, DRAINED)
//   STAT_W      : width of the optional statistics counters
//   rr_pick     : reference round-robin pick on up to RR_MAX requesters;
//                 request bits above the real requester count must be zero,
//                 which makes the wrap at RR_MAX equivalent to a wrap at the
//                 real requester count.
// -----------------------------------------------------------------------------
package credit_arb_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    DRAINED = 2'd2
  } arb_state_e;

  localparam int STAT_W = 16;
  localparam int RR_MAX = 32;

  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input logic [4:0]        ptr);
    logic [RR_MAX-1:0] gnt;
    logic              found;
    logic [4:0]        idx;
    gnt   = {RR_MAX{1'b0}};
    found = 1'b0;
    for (int k = 0; k < RR_MAX; k++) begin
      idx = ptr + 5'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/credit_rr_pick.sv
// -----------------------------------------------------------------------------
// credit_rr_pick
// Combinational round-robin picker: rotates the request vector so that bit 0
// is the pointer position, takes the lowest set bit, and rotates back.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  IW       highest-priority requester (must be < NUM_REQ)
//   grant out NUM_REQ  one-hot winner (all zero when no request)
//   idx   out IW       winner id
//   any   out 1        at least one request present
// -----------------------------------------------------------------------------
module credit_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot_s;
  logic [IW-1:0]      off_s;
  logic [IW:0]        sum_s;

  // Rotate, priority-encode from the pointer, then map the offset back to an id
  always_comb begin
    // rot_s[k] is requester (ptr + k) mod NUM_REQ
    rot_s = NUM_REQ'({req, req} >> ptr);
    off_s = {IW{1'b0}};
    any   = 1'b0;
    // Descending scan: the last hit written is the lowest offset
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        off_s = IW'(k);
        any   = 1'b1;
      end else begin
        off_s = off_s;
      end
    end
    sum_s = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= (IW+1)'(NUM_REQ)) begin
      sum_s = sum_s - (IW+1)'(NUM_REQ);
    end else begin
      sum_s = sum_s;
    end
    idx = sum_s[IW-1:0];
    if (any) begin
      grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    end else begin
      grant = {NUM_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/credit_rr_arbiter.sv
// -----------------------------------------------------------------------------
// credit_rr_arbiter
// Round-robin arbiter sharing one credit-controlled FIFO push port among
// NUM_REQ requesters. One beat is granted per cycle while credits remain; the
// winning beat is pushed on a registered valid/data port one cycle later.
// A drain handshake stops granting and reports when all credits are back.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   req_valid      per-requester beat present
//   req_data       flattened payloads, slice i = requester i
//   req_grant      one-hot combinational accept
//   out_valid/out_data/out_src  registered push to the shared FIFO
//   out_credit     one pulse per downstream slot freed
//   drain_req      level request to quiesce; drain_done when pool is full
//   credits_avail  current credit count
//   cred_ovf_err   sticky: credit returned while the pool was full
// Optional feature macro: CREDIT_RR_ARBITER_STATS_EN adds grant_cnt
// (per-requester saturating grant counters) and stall_cnt (cycles blocked
// on credits while running).
// -----------------------------------------------------------------------------
module credit_rr_arbiter
  import credit_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 8,
  parameter  int DOWN_CREDITS = 16,
  localparam int CW           = $clog2(DOWN_CREDITS + 1),
  localparam int IW           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_grant,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [IW-1:0]                 out_src,
  input  logic                          out_credit,
  input  logic                          drain_req,
  output logic                          drain_done,
  output logic [CW-1:0]                 credits_avail,
  output logic                          cred_ovf_err
`ifdef CREDIT_RR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]     grant_cnt,
  output logic [STAT_W-1:0]             stall_cnt
`endif
);

  localparam logic [CW-1:0] CNT_FULL = CW'(DOWN_CREDITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] PTR_LAST = IW'(NUM_REQ - 1);

  arb_state_e             state_r;
  logic [CW-1:0]          cnt_r;
  logic [IW-1:0]          rr_ptr_r;
  logic                   drain_done_r;
  logic                   ovf_r;
  logic                   out_valid_r;
  logic [DATA_WIDTH-1:0]  out_data_r;
  logic [IW-1:0]          out_src_r;

  logic [NUM_REQ-1:0]     pick_grant_s;
  logic [IW-1:0]          pick_idx_s;
  logic                   pick_any_s;
  logic                   can_grant_s;

  credit_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Grant only from the registered credit count, so a returning credit is usable next cycle
  always_comb begin
    can_grant_s = (state_r == RUN) && (cnt_r != {CW{1'b0}}) && pick_any_s;
    if (can_grant_s) begin
      req_grant = pick_grant_s;
    end else begin
      req_grant = {NUM_REQ{1'b0}};
    end
  end

  // Drain FSM; drain_done is registered alongside the state it reports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= RUN;
      drain_done_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (drain_req) begin
            state_r <= DRAIN;
          end else begin
            state_r <= RUN;
          end
          drain_done_r <= 1'b0;
        end
        DRAIN: begin
          if (!drain_req) begin
            state_r      <= RUN;
            drain_done_r <= 1'b0;
          end else if (cnt_r == CNT_FULL) begin
            state_r      <= DRAINED;
            drain_done_r <= 1'b1;
          end else begin
            state_r      <= DRAIN;
            drain_done_r <= 1'b0;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state_r      <= RUN;
            drain_done_r <= 1'b0;
          end else begin
            state_r      <= DRAINED;
            drain_done_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= RUN;
          drain_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Credit pool: a grant spends one, a return adds one, a return into a full pool is flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= CNT_FULL;
      ovf_r <= 1'b0;
    end else begin
      if (can_grant_s && !out_credit) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else if (!can_grant_s && out_credit) begin
        if (cnt_r == CNT_FULL) begin
          ovf_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Round-robin pointer and the registered push port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r    <= {IW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_src_r   <= {IW{1'b0}};
    end else begin
      if (can_grant_s) begin
        rr_ptr_r    <= (pick_idx_s == PTR_LAST) ? {IW{1'b0}} : pick_idx_s + IW'(1);
        out_valid_r <= 1'b1;
        out_data_r  <= req_data[pick_idx_s*DATA_WIDTH +: DATA_WIDTH];
        out_src_r   <= pick_idx_s;
      end else begin
        rr_ptr_r    <= rr_ptr_r;
        out_valid_r <= 1'b0;
        out_data_r  <= {DATA_WIDTH{1'b0}};
        out_src_r   <= {IW{1'b0}};
      end
    end
  end

  assign out_valid     = out_valid_r;
  assign out_data      = out_data_r;
  assign out_src       = out_src_r;
  assign drain_done    = drain_done_r;
  assign credits_avail = cnt_r;
  assign cred_ovf_err  = ovf_r;

`ifdef CREDIT_RR_ARBITER_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic [STAT_W-1:0] grant_cnt_r [NUM_REQ];
  logic [STAT_W-1:0] stall_cnt_r;

  // Saturating per-requester grant counters and credit-stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grant_cnt_r[i] <= {STAT_W{1'b0}};
      end
      stall_cnt_r <= {STAT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_grant[i] && (grant_cnt_r[i] != STAT_MAX)) begin
          grant_cnt_r[i] <= grant_cnt_r[i] + STAT_ONE;
        end else begin
          grant_cnt_r[i] <= grant_cnt_r[i];
        end
      end
      if ((state_r == RUN) && (cnt_r == {CW{1'b0}}) && (|req_valid) &&
          (stall_cnt_r != STAT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + STAT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // Flatten the counter array onto the output bus
  always_comb begin
    grant_cnt = {(NUM_REQ*STAT_W){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*STAT_W +: STAT_W] = grant_cnt_r[i];
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule
